// File: rtl/core_run_monitor.sv
// Run monitor for the RV32IMC core: halt detection, run statistics, then a data-memory compare sweep.
// Define RUN_MON_STALL_PROFILE_EN to build the longest-stall-run profiler behind stall_max.
module core_run_monitor #(
   parameter int INST_W      = 32,
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 32,
   parameter int CNT_W       = 32,
   parameter int HALT_REPEAT = 10,
   parameter int SWEEP_BASE  = 0,
   parameter int SWEEP_LAST  = 2**ADDR_W - 1,
   parameter int RD_LAT      = 1
) (
   input  logic              CLK,
   input  logic              rst,
   input  logic [INST_W-1:0] inst,
   input  logic              stall,
   input  logic              flush,
   output logic [ADDR_W-1:0] con_addr,
   input  logic [DATA_W-1:0] con_out,
   input  logic [DATA_W-1:0] exp_data,
   output logic              halted,
   output logic              done,
   output logic [CNT_W-1:0]  cycle_count,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count,
   output logic [CNT_W-1:0]  stall_max,
   output logic [CNT_W-1:0]  pass_count,
   output logic [CNT_W-1:0]  fail_count,
   output logic              first_fail_valid,
   output logic [ADDR_W-1:0] first_fail_addr,
   output logic              cmp_valid,
   output logic              cmp_pass,
   output logic [ADDR_W-1:0] cmp_addr
);

   typedef enum logic [1:0] {S_RUN, S_SWEEP, S_DRAIN, S_DONE} state_t;

   localparam int                REP_W     = $clog2(HALT_REPEAT + 1);
   localparam logic [REP_W-1:0]  REP_HALT  = REP_W'(HALT_REPEAT - 1);
   localparam logic [REP_W-1:0]  REP_SAT   = REP_W'(HALT_REPEAT);
   localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(SWEEP_BASE);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SWEEP_LAST);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   state_t              state, state_next;
   logic [INST_W-1:0]   last_inst;
   logic [REP_W-1:0]    rep;
   logic                inst_same, halt_hit, issue, sweep_end, pipe_busy, data_match;
   logic [RD_LAT-1:0]   pipe_valid;
   logic [ADDR_W-1:0]   pipe_addr [RD_LAT];

   assign inst_same  = (inst == last_inst);
   assign halt_hit   = (state == S_RUN) && inst_same && (rep == REP_HALT);
   assign issue      = (state == S_SWEEP);
   assign sweep_end  = issue && (con_addr == LAST_ADDR);
   assign pipe_busy  = |pipe_valid;
   assign data_match = (con_out == exp_data);

   // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK) begin
      if (rst) state <= S_RUN;
      else     state <= state_next;
   end

   always_comb begin
      // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
      state_next = state;
      case (state)
         S_RUN:   if (halt_hit)   state_next = S_SWEEP;
         S_SWEEP: if (sweep_end)  state_next = S_DRAIN;
         S_DRAIN: if (!pipe_busy) state_next = S_DONE;
         default: state_next = S_DONE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         last_inst   <= '0;
         rep         <= '0;
         cycle_count <= '0;
         stall_count <= '0;
         flush_count <= '0;
         halted      <= 1'b0;
         con_addr    <= '0;
      end else begin
         case (state)
            S_RUN: begin
               if (inst_same) begin
                  if (rep != REP_SAT) rep <= rep + REP_W'(1);
               end else begin
                  rep       <= '0;
                  last_inst <= inst;
               end
               cycle_count <= sat_inc(cycle_count);
               if (stall) stall_count <= sat_inc(stall_count);
               if (flush) flush_count <= sat_inc(flush_count);
               if (halt_hit) begin
                  halted   <= 1'b1;
                  con_addr <= BASE_ADDR;
               end
            end
            S_SWEEP: if (!sweep_end) con_addr <= con_addr + ADDR_W'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (rst)                               done <= 1'b0;
      else if (state == S_DRAIN && !pipe_busy) done <= 1'b1;
   end

   // Read-latency pipe: the valid bits are reset so a reset mid-sweep drops all in-flight compares.
   always_ff @(posedge CLK) begin
      if (rst) begin
         pipe_valid       <= '0;
         cmp_valid        <= 1'b0;
         cmp_pass         <= 1'b0;
         cmp_addr         <= '0;
         pass_count       <= '0;
         fail_count       <= '0;
         first_fail_valid <= 1'b0;
         first_fail_addr  <= '0;
      end else if (state != S_DONE) begin
         pipe_valid[0] <= issue;
         for (int i = 1; i < RD_LAT; i++) pipe_valid[i] <= pipe_valid[i-1];
         cmp_valid <= pipe_valid[RD_LAT-1];
         if (pipe_valid[RD_LAT-1]) begin
            cmp_addr <= pipe_addr[RD_LAT-1];
            cmp_pass <= data_match;
            if (data_match) begin
               pass_count <= sat_inc(pass_count);
            end else begin
               fail_count <= sat_inc(fail_count);
               if (!first_fail_valid) begin
                  first_fail_valid <= 1'b1;
                  first_fail_addr  <= pipe_addr[RD_LAT-1];
               end
            end
         end
      end
   end

   // NOTE: the address pipe has no reset; its contents are only used where the matching valid bit is set.
   always_ff @(posedge CLK) begin
      pipe_addr[0] <= con_addr;
      for (int i = 1; i < RD_LAT; i++) pipe_addr[i] <= pipe_addr[i-1];
   end

`ifdef RUN_MON_STALL_PROFILE_EN
   logic [CNT_W-1:0] stall_run, stall_run_inc;

   assign stall_run_inc = sat_inc(stall_run);

   always_ff @(posedge CLK) begin
      if (rst) begin
         stall_run <= '0;
         stall_max <= '0;
      end else if (state == S_RUN) begin
         if (stall) begin
            stall_run <= stall_run_inc;
            if (stall_run_inc > stall_max) stall_max <= stall_run_inc;
         end else begin
            stall_run <= '0;
         end
      end
   end
`else
   assign stall_max = '0;
`endif

endmodule

// File: tb/tb_core_run_monitor.sv
// Directed bench for core_run_monitor: halt detection, statistics, compare sweep, mid-sweep reset, saturation.
module tb_core_run_monitor;

   localparam int ADDR_W = 10;
   localparam int CNT_W  = 32;
`ifdef RUN_MON_STALL_PROFILE_EN
   localparam bit PROF = 1'b1;
`else
   localparam bit PROF = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst, stall, flush;
   logic [31:0]       inst;
   logic [ADDR_W-1:0] con_addr, first_fail_addr, cmp_addr;
   logic [31:0]       con_out, exp_data;
   logic              halted, done, first_fail_valid, cmp_valid, cmp_pass;
   logic [CNT_W-1:0]  cycle_count, stall_count, flush_count, stall_max, pass_count, fail_count;

   logic              s_rst, s_stall, s_halted, s_done, s_ffv, s_cmp_valid, s_cmp_pass;
   logic [31:0]       s_inst;
   logic [3:0]        s_con_addr, s_ffa, s_cmp_addr;
   logic [3:0]        s_cycle, s_stall_cnt, s_flush_cnt, s_stall_max, s_pass, s_fail;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   core_run_monitor #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .SWEEP_BASE(0), .SWEEP_LAST(7), .RD_LAT(2)) dut (
      .CLK(clk), .rst(rst), .inst(inst), .stall(stall), .flush(flush),
      .con_addr(con_addr), .con_out(con_out), .exp_data(exp_data),
      .halted(halted), .done(done),
      .cycle_count(cycle_count), .stall_count(stall_count), .flush_count(flush_count),
      .stall_max(stall_max), .pass_count(pass_count), .fail_count(fail_count),
      .first_fail_valid(first_fail_valid), .first_fail_addr(first_fail_addr),
      .cmp_valid(cmp_valid), .cmp_pass(cmp_pass), .cmp_addr(cmp_addr)
   );

   core_run_monitor #(.ADDR_W(4), .CNT_W(4), .SWEEP_LAST(3)) dut_sat (
      .CLK(clk), .rst(s_rst), .inst(s_inst), .stall(s_stall), .flush(1'b0),
      .con_addr(s_con_addr), .con_out(32'h0), .exp_data(32'h0),
      .halted(s_halted), .done(s_done),
      .cycle_count(s_cycle), .stall_count(s_stall_cnt), .flush_count(s_flush_cnt),
      .stall_max(s_stall_max), .pass_count(s_pass), .fail_count(s_fail),
      .first_fail_valid(s_ffv), .first_fail_addr(s_ffa),
      .cmp_valid(s_cmp_valid), .cmp_pass(s_cmp_pass), .cmp_addr(s_cmp_addr)
   );

   // Console memory model with two-cycle read latency; expected data differs at words 3 and 6.
   logic [ADDR_W-1:0] rd_a1, rd_a2;
   always @(posedge clk) begin
      rd_a1 <= con_addr;
      rd_a2 <= rd_a1;
   end
   assign con_out  = 32'hDEAD_0000 ^ {22'h0, rd_a2};
   assign exp_data = con_out ^ (((rd_a2 == 10'd3) || (rd_a2 == 10'd6)) ? 32'h1 : 32'h0);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_halted"}, 64'(halted), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_con_addr"}, 64'(con_addr), 64'd0);
      check({tag, "_cycle"}, 64'(cycle_count), 64'd0);
      check({tag, "_stall"}, 64'(stall_count), 64'd0);
      check({tag, "_flush"}, 64'(flush_count), 64'd0);
      check({tag, "_stall_max"}, 64'(stall_max), 64'd0);
      check({tag, "_pass"}, 64'(pass_count), 64'd0);
      check({tag, "_fail"}, 64'(fail_count), 64'd0);
      check({tag, "_ffv"}, 64'(first_fail_valid), 64'd0);
      check({tag, "_ffa"}, 64'(first_fail_addr), 64'd0);
      check({tag, "_cmp_valid"}, 64'(cmp_valid), 64'd0);
      check({tag, "_cmp_pass"}, 64'(cmp_pass), 64'd0);
      check({tag, "_cmp_addr"}, 64'(cmp_addr), 64'd0);
   endtask

   // Call on the sample where halted first reads 1; stall/flush/inst are toggled to show they are ignored.
   task automatic run_sweep(input string tag, input int exp_cycles);
      int k = 0;
      int n_cmp = 0;
      int first_k = -1;
      logic [ADDR_W-1:0] want_addr;
      stall = 1'b1;
      flush = 1'b1;
      while (!done && k < 60) begin
         inst = 32'h7700 + k;
         step();
         k++;
         if (cmp_valid) begin
            if (first_k < 0) first_k = k;
            want_addr = ADDR_W'(n_cmp);
            check({tag, "_cmp_addr"}, 64'(cmp_addr), 64'(want_addr));
            check({tag, "_cmp_pass"}, 64'(cmp_pass), (n_cmp == 3 || n_cmp == 6) ? 64'd0 : 64'd1);
            n_cmp++;
         end
      end
      check({tag, "_done_latency"}, 64'(k), 64'd11);
      check({tag, "_first_cmp_latency"}, 64'(first_k), 64'd3);
      check({tag, "_n_cmp"}, 64'(n_cmp), 64'd8);
      check({tag, "_pass"}, 64'(pass_count), 64'd6);
      check({tag, "_fail"}, 64'(fail_count), 64'd2);
      check({tag, "_ffv"}, 64'(first_fail_valid), 64'd1);
      check({tag, "_ffa"}, 64'(first_fail_addr), 64'd3);
      check({tag, "_last_addr"}, 64'(con_addr), 64'd7);
      check({tag, "_cycle"}, 64'(cycle_count), 64'(exp_cycles));
      check({tag, "_stall_ignored"}, 64'(stall_count), 64'd0);
      check({tag, "_flush_ignored"}, 64'(flush_count), 64'd0);
      repeat (3) step();
      check({tag, "_hold_done"}, 64'(done), 64'd1);
      check({tag, "_hold_cmp_valid"}, 64'(cmp_valid), 64'd0);
      check({tag, "_hold_pass"}, 64'(pass_count), 64'd6);
      check({tag, "_hold_addr"}, 64'(con_addr), 64'd7);
      check({tag, "_hold_cycle"}, 64'(cycle_count), 64'(exp_cycles));
      stall = 1'b0;
      flush = 1'b0;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; inst = 32'h0;
      s_rst = 1'b1; s_stall = 1'b0; s_inst = 32'h0;
      step();
      step();
      rst = 1'b0;
      check_reset_state("reset");

      // Stall 3, idle 1, stall 5; flush on the first two cycles; distinct fetches avoid halt.
      for (int i = 0; i < 9; i++) begin
         inst  = 32'h100 + i;
         stall = (i < 3) || (i >= 4);
         flush = (i < 2);
         step();
      end
      stall = 1'b0;
      flush = 1'b0;
      check("sf_stall_count", 64'(stall_count), 64'd8);
      check("sf_flush_count", 64'(flush_count), 64'd2);
      check("sf_stall_max", 64'(stall_max), PROF ? 64'd5 : 64'd0);
      check("sf_cycle", 64'(cycle_count), 64'd9);
      check("sf_halted", 64'(halted), 64'd0);

      // Near miss: 10 fetches of A (9 equal compares), then B needs a full 10 equal compares.
      do_reset();
      inst = 32'h55;
      repeat (10) step();
      check("nm_after_a", 64'(halted), 64'd0);
      inst = 32'h66;
      repeat (10) step();
      check("nm_before_halt", 64'(halted), 64'd0);
      step();
      check("nm_halted", 64'(halted), 64'd1);
      check("nm_cycle", 64'(cycle_count), 64'd21);

      // Halt after 0x1, 0x2 then eleven 0x13 fetches, followed by the full compare sweep.
      do_reset();
      inst = 32'h1;
      step();
      inst = 32'h2;
      step();
      inst = 32'h13;
      repeat (10) step();
      check("halt_early", 64'(halted), 64'd0);
      step();
      check("halt_rise", 64'(halted), 64'd1);
      check("halt_cycle", 64'(cycle_count), 64'd13);
      check("halt_con_addr", 64'(con_addr), 64'd0);
      run_sweep("sweep1", 13);

      // All-zero stream counts from the first cycle; reset lands mid-sweep at address 4.
      do_reset();
      inst = 32'h0;
      repeat (9) step();
      check("zero_early", 64'(halted), 64'd0);
      step();
      check("zero_halted", 64'(halted), 64'd1);
      check("zero_cycle", 64'(cycle_count), 64'd10);
      for (int k = 0; k < 20 && con_addr != 10'd4; k++) step();
      check("mid_addr", 64'(con_addr), 64'd4);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset_state("mid_reset");
      inst = 32'h0;
      step();
      check("mid_no_stray_cmp", 64'(cmp_valid), 64'd0);
      check("mid_no_stray_pass", 64'(pass_count), 64'd0);
      repeat (8) step();
      check("rerun_early", 64'(halted), 64'd0);
      step();
      check("rerun_halted", 64'(halted), 64'd1);
      run_sweep("sweep2", 10);

      // Saturation on a 4-bit-counter instance.
      s_rst = 1'b1;
      step();
      s_rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         s_inst  = 32'h1000 + i;
         s_stall = 1'b1;
         step();
      end
      s_stall = 1'b0;
      check("sat_stall_count", 64'(s_stall_cnt), 64'd15);
      check("sat_cycle", 64'(s_cycle), 64'd15);
      check("sat_stall_max", 64'(s_stall_max), PROF ? 64'd15 : 64'd0);
      check("sat_halted", 64'(s_halted), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
